seq_det_param: RTL
==================

Name: seq_det_param

Overview:
- Parametrised Mealy serial-pattern detector; successor to the fixed-pattern single-bit detector.
- Pattern width is a parameter; pattern is runtime-loadable; overlapping or non-overlapping detection is selected by an input.
- Sits on a serial bit stream, one bit per enabled clock; the Mealy match flag feeds downstream control logic.
- Optional saturating match counter for debug/statistics.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- DEFAULT_PAT, 4'b1011, pattern register reset value; PAT_W bits wide.
- CNT_W, 8, match counter width (used only with SEQ_DET_COUNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid; x is sampled only when en=1.
- x  input  1  serial data bit.
- load  input  1  pattern load strobe.
- pat_in  input  PAT_W  new pattern; pat_in[PAT_W-1] is the first bit of the sequence.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- y  output  1  Mealy match flag, combinational.
- match_cnt  output  CNT_W  saturating match count (present only with SEQ_DET_COUNT_EN).

Behaviour:
- Reset (rst=0, asynchronous):
  - pat_r=DEFAULT_PAT, hist=0, fill=0, match_cnt=0.
  - y=0 while rst=0.
- State:
  - pat_r: PAT_W-bit pattern register.
  - hist: PAT_W-1 bit history; hist[0] is the newest bit.
  - fill: counter of width $clog2(PAT_W), saturating at PAT_W-1.
- Match (combinational):
  - y = en & ~load & (fill==PAT_W-1) & ({hist,x}==pat_r).
  - Zero-cycle latency: y asserts in the same cycle the last pattern bit is presented.
- Clock edge with load=1 (load has priority over en):
  - pat_r<=pat_in, hist<=0, fill<=0.
  - x is discarded that cycle.
- Clock edge with load=0 and en=1:
  - If y=1 and overlap=0: hist<=0, fill<=0, so the matched bits are not reused.
  - Otherwise: hist<={hist[PAT_W-3:0],x}, fill<=min(fill+1, PAT_W-1).
  - For PAT_W=2, hist is 1 bit and the shift reduces to hist<=x.
- Clock edge with load=0 and en=0: all state holds; y=0.
- overlap may change on any cycle and takes effect for the current cycle's match.
- Wrap-around: fill saturates; hist is a pure shift register with no wrap.
- Reset mid-sequence: partial history is lost; a full PAT_W fresh bits are required before the next match.
- A pattern of all-zeros or all-ones is legal; with overlap=1 it matches on every enabled bit once fill saturates.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - match_cnt increments on each clock edge where y=1.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset and by load=1.
- Not defined:
  - match_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, default pattern 1011, overlap=1, en=1, stream 1,0,1,1,0,1,1 -> y=1 on bit 4 and on bit 7 only; match_cnt=2.
- Same stream with overlap=0 -> y=1 on bit 4 only (fill is cleared after bit 4, and 3 bits are insufficient for a match by bit 7); match_cnt=1.
- load=1 with pat_in=4'b0110 (match_cnt was 2), then stream 0,1,1,0,1,1,0 with overlap=1 -> on the load cycle, y=0 and x is ignored; y=1 on bits 4 and 7; match_cnt cleared to 0 by the load, ending at 2.
- Default pattern, stream 1,0,1 then en=0 for 3 cycles (x toggling), then en=1 with x=1 -> y=0 during the en=0 cycles; y=1 when the final 1 is applied.
- Default pattern, stream 1,0,1, assert rst=0 between clock edges, release, then x=1 -> y=0, no match; a subsequent full 1,0,1,1 -> y=1 on its 4th bit.
- SEQ_DET_COUNT_EN with CNT_W=2, pattern 1111, overlap=1, 8 consecutive 1s -> y=1 on bits 4..8 (5 matches); match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_det_param.sv
// seq_det_param: runtime-loadable Mealy serial-pattern detector.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt output.
module seq_det_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
`ifdef SEQ_DET_COUNT_EN
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
`else
  output logic             y
`endif
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  generate
    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
      $error("PAT_W out of range 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
    end
  endgenerate

  logic [PAT_W-1:0] pat_r, pat_nx;
  logic [PAT_W-2:0] hist, hist_nx, hist_sh;
  logic [FW-1:0]    fill, fill_nx;
  logic             hit;

  // A 2-bit pattern keeps a single history bit, so the shift
  // degenerates to a plain copy of the incoming bit.
  generate
    if (PAT_W == 2) begin : g_sh1
      assign hist_sh = x;
    end else begin : g_shn
      assign hist_sh = {hist[PAT_W-3:0], x};
    end
  endgenerate

  // Mealy match and next-state selection; load wins over en.
  always_comb begin
    pat_nx  = pat_r;
    hist_nx = hist;
    fill_nx = fill;
    hit     = (fill == FILL_MAX) && ({hist, x} == pat_r);
    y       = rst & en & ~load & hit;
    if (load) begin
      pat_nx  = pat_in;
      hist_nx = '0;
      fill_nx = '0;
    end else if (en) begin
      if (y && !overlap) begin
        hist_nx = '0;
        fill_nx = '0;
      end else begin
        hist_nx = hist_sh;
        fill_nx = (fill == FILL_MAX) ? fill : fill + FW'(1);
      end
    end
  end

  // Pattern, history and fill registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r <= DEFAULT_PAT;
      hist  <= '0;
      fill  <= '0;
    end else begin
      pat_r <= pat_nx;
      hist  <= hist_nx;
      fill  <= fill_nx;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  // Saturating match counter, cleared on pattern load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (load) begin
      match_cnt <= '0;
    end else if (y && match_cnt != {CNT_W{1'b1}}) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
